// File: rtl/rv32_dmem_responder_pkg.sv
// Shared definitions for the RV32 data-memory responder.
// Contents:
//   LANES / LANE_W / WORD_W - byte-lane geometry of the 32-bit data bus
//   state_t                 - responder FSM encoding (IDLE / WAIT / RESP)
//   merge_lanes()           - byte-lane merge of a store into an existing word
package rv32_dmem_responder_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] merge_lanes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [LANES-1:0]  be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rv32_dmem_responder_ram.sv
// Synchronous word RAM, 2^ADDR_WIDTH x 32, with per-lane write enables.
// The read port is registered and write-first: when a read and a write hit
// the same word in one cycle, the read returns the byte-merged new word.
// Ports:
//   i_clk    - clock
//   i_we     - per-lane write enable (all zero = no write)
//   i_waddr  - word address of the write
//   i_wdata  - store data
//   i_re     - read enable; o_rdata only updates when set
//   i_raddr  - word address of the read
//   o_rdata  - registered read data
module rv32_dmem_responder_ram
    import rv32_dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic [LANES-1:0]      i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WORD_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WORD_W-1:0]     o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_WIDTH];
    logic [WORD_W-1:0] w_merged;

    assign w_merged = merge_lanes(r_mem[i_waddr], i_wdata, i_we);

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_we[i]) r_mem[i_waddr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
        end
        if (i_re) begin
            // Bypass keeps the read write-first on an address match.
            o_rdata <= ((|i_we) && (i_waddr == i_raddr)) ? w_merged : r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Responder end of the RV32 data-memory bus. Holds a byte-enabled word RAM
// at BASE_ADDR, stalls reads for READ_WAIT_STATES cycles, completes writes
// with no stall, and flags out-of-window accesses on o_bus_err.
// Ports:
//   i_clk, i_reset_n  - clock, asynchronous active-low reset
//   i_address         - byte address (bits [1:0] ignored)
//   i_write           - single-cycle store strobe
//   i_writedata       - store data
//   i_byteenable      - store lane enables
//   i_read            - read request, held until o_waitrequest is low
//   o_readdata        - read data, valid when i_read & !o_waitrequest
//   o_waitrequest     - read stall
//   o_bus_err         - one-cycle pulse on an out-of-window access
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no read in flight; a read here is accepted (first stall cycle)
// WAIT  | remaining stall cycles; RAM read issued in the last one
// RESP  | RAM data presented, waitrequest low, always back to IDLE
module rv32_dmem_responder
    import rv32_dmem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_1000,
    parameter int          ADDR_WIDTH       = 10,
    parameter int          READ_WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_address,
    input  logic        i_write,
    input  logic [31:0] i_writedata,
    input  logic [3:0]  i_byteenable,
    input  logic        i_read,
    output logic [31:0] o_readdata,
    output logic        o_waitrequest,
    output logic        o_bus_err
);

    localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT_STATES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic                  r_in_win;
    logic [31:0]           r_readdata;

    logic                  w_addr_in_win;
    logic [ADDR_WIDTH-1:0] w_addr_word;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_wr_err;
    logic [3:0]            w_we;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_resp_data;
    logic                  w_unused_addr_lsb;

    // Window is 4*2^ADDR_WIDTH aligned, so a compare of the upper bits suffices.
    assign w_addr_in_win     = (i_address[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_addr_word       = i_address[ADDR_WIDTH+1:2];
    assign w_unused_addr_lsb = ^i_address[1:0];

    assign w_we     = (i_write && w_addr_in_win) ? i_byteenable : 4'b0000;
    assign w_wr_err = i_write && !w_addr_in_win && (|i_byteenable);

    // The IDLE cycle that accepts a read is itself the first stall cycle, so
    // r_wait_cnt holds the stall cycles still to come including the current
    // WAIT cycle; the RAM read goes out when it reaches 1. With a single wait
    // state the read is issued straight from IDLE using the live address.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_raddr     = r_word_addr;
        case (r_state)
            ST_IDLE: begin
                if (i_read) begin
                    w_accept = 1'b1;
                    if (WAIT_LOAD == 4'd0) begin
                        w_issue     = w_addr_in_win;
                        w_raddr     = w_addr_word;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_issue     = r_in_win;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_word_addr <= '0;
            r_in_win    <= 1'b0;
            r_readdata  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_word_addr <= w_addr_word;
                r_in_win    <= w_addr_in_win;
                r_wait_cnt  <= WAIT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (r_state == ST_RESP) r_readdata <= w_resp_data;
        end
    end

    assign w_resp_data   = r_in_win ? w_ram_rdata : 32'h0;
    assign o_readdata    = (r_state == ST_RESP) ? w_resp_data : r_readdata;
    assign o_waitrequest = i_read && (r_state != ST_RESP);
    assign o_bus_err     = w_wr_err || ((r_state == ST_RESP) && !r_in_win);

    rv32_dmem_responder_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_addr_word),
        .i_wdata (i_writedata),
        .i_re    (w_issue),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_rv32_dmem_responder.sv
module tb_rv32_dmem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a1_addr = '0, a1_wdata = '0, d1_rdata;
    logic        a1_wr = 1'b0, a1_rd = 1'b0, d1_wait, d1_err;
    logic [3:0]  a1_be = '0;
    logic [31:0] a3_addr = '0, a3_wdata = '0, d3_rdata;
    logic        a3_wr = 1'b0, a3_rd = 1'b0, d3_wait, d3_err;
    logic [3:0]  a3_be = '0;

    int total = 0;
    int bad   = 0;
    exp_t q1[$];
    exp_t q3[$];
    int wcnt1 = 0;
    int wcnt3 = 0;

    rv32_dmem_responder #(.BASE_ADDR(32'h0000_1000), .ADDR_WIDTH(10), .READ_WAIT_STATES(1)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_address(a1_addr), .i_write(a1_wr),
        .i_writedata(a1_wdata), .i_byteenable(a1_be), .i_read(a1_rd),
        .o_readdata(d1_rdata), .o_waitrequest(d1_wait), .o_bus_err(d1_err));

    rv32_dmem_responder #(.BASE_ADDR(32'h0000_1000), .ADDR_WIDTH(10), .READ_WAIT_STATES(3)) u_dut3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_address(a3_addr), .i_write(a3_wr),
        .i_writedata(a3_wdata), .i_byteenable(a3_be), .i_read(a3_rd),
        .o_readdata(d3_rdata), .o_waitrequest(d3_wait), .o_bus_err(d3_err));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Response monitors: count stall cycles and pop/compare on each response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !a1_rd) begin
            wcnt1 = 0;
        end else if (d1_wait) begin
            wcnt1++;
            if (!a1_wr) chk("d1_err_during_wait", {31'b0, d1_err}, 32'h0);
        end else begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_resp", 32'h1, 32'h0);
            end else begin
                e = q1.pop_front();
                chk("d1_rdata", d1_rdata, e.data);
                chk("d1_rd_err", {31'b0, d1_err}, {31'b0, e.err});
                chk("d1_wait_cycles", 32'(wcnt1), 32'(e.waits));
            end
            wcnt1 = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !a3_rd) begin
            wcnt3 = 0;
        end else if (d3_wait) begin
            wcnt3++;
            if (!a3_wr) chk("d3_err_during_wait", {31'b0, d3_err}, 32'h0);
        end else begin
            if (q3.size() == 0) begin
                chk("d3_unexpected_resp", 32'h1, 32'h0);
            end else begin
                e = q3.pop_front();
                chk("d3_rdata", d3_rdata, e.data);
                chk("d3_rd_err", {31'b0, d3_err}, {31'b0, e.err});
                chk("d3_wait_cycles", 32'(wcnt3), 32'(e.waits));
            end
            wcnt3 = 0;
        end
    end

    task automatic push_exp(input int sel, input logic [31:0] data, input logic err);
        exp_t e;
        e.data  = data;
        e.err   = err;
        e.waits = (sel == 1) ? 1 : 3;
        if (sel == 1) q1.push_back(e);
        else          q3.push_back(e);
    endtask

    task automatic wait_resp(input int sel, output int cycles);
        logic w;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            w = (sel == 1) ? d1_wait : d3_wait;
        end while (w && cycles < 40);
        if (w) chk("resp_timeout", 32'h1, 32'h0);
    endtask

    task automatic do_write(input int sel, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic exp_err);
        if (sel == 1) begin a1_addr = addr; a1_wdata = data; a1_be = be; a1_wr = 1'b1; end
        else          begin a3_addr = addr; a3_wdata = data; a3_be = be; a3_wr = 1'b1; end
        @(negedge clk);
        chk("wr_bus_err", {31'b0, (sel == 1) ? d1_err : d3_err}, {31'b0, exp_err});
        chk("wr_no_wait", {31'b0, (sel == 1) ? d1_wait : d3_wait}, 32'h0);
        @(posedge clk); #1;
        if (sel == 1) a1_wr = 1'b0;
        else          a3_wr = 1'b0;
    endtask

    task automatic do_read(input int sel, input logic [31:0] addr, input logic [31:0] data,
                           input logic err);
        int c;
        push_exp(sel, data, err);
        if (sel == 1) begin a1_addr = addr; a1_rd = 1'b1; end
        else          begin a3_addr = addr; a3_rd = 1'b1; end
        wait_resp(sel, c);
        @(posedge clk); #1;
        if (sel == 1) a1_rd = 1'b0;
        else          a3_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_d1_rdata", d1_rdata, 32'h0);
        chk("rst_d1_wait", {31'b0, d1_wait}, 32'h0);
        chk("rst_d1_err", {31'b0, d1_err}, 32'h0);
        chk("rst_d3_rdata", d3_rdata, 32'h0);
        chk("rst_d3_err", {31'b0, d3_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // N=1: basic write/read
        do_write(1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0);
        do_read (1, 32'h1000, 32'hCAFEF00D, 1'b0);

        // Lane writes and byteenable=0 no-op
        do_write(1, 32'h1008, 32'h11223344, 4'hF, 1'b0);
        do_write(1, 32'h1008, 32'hAABBCCDD, 4'b0101, 1'b0);
        do_read (1, 32'h1008, 32'h11BB33DD, 1'b0);
        do_write(1, 32'h1008, 32'hFFFFFFFF, 4'b0000, 1'b0);
        do_read (1, 32'h1008, 32'h11BB33DD, 1'b0);

        // N=1: read and write of the same word in the read-issue cycle
        do_write(1, 32'h100C, 32'h01020304, 4'hF, 1'b0);
        push_exp(1, 32'h5A5A5A5A, 1'b0);
        a1_addr = 32'h100C; a1_rd = 1'b1;
        a1_wdata = 32'h5A5A5A5A; a1_be = 4'hF; a1_wr = 1'b1;
        @(posedge clk); #1;
        a1_wr = 1'b0;
        wait_resp(1, c1);
        @(posedge clk); #1;
        a1_rd = 1'b0;

        // Window boundaries
        do_write(1, 32'h1FFC, 32'h13579BDF, 4'hF, 1'b0);
        do_read (1, 32'h1FFC, 32'h13579BDF, 1'b0);
        do_read (1, 32'h0FFC, 32'h00000000, 1'b1);
        do_write(1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b1);
        do_read (1, 32'h1000, 32'hCAFEF00D, 1'b0);

        // N=3: single read, then back-to-back reads
        do_write(3, 32'h1004, 32'h600DF00D, 4'hF, 1'b0);
        do_write(3, 32'h1010, 32'h76543210, 4'hF, 1'b0);
        do_read (3, 32'h1004, 32'h600DF00D, 1'b0);
        push_exp(3, 32'h600DF00D, 1'b0);
        push_exp(3, 32'h76543210, 1'b0);
        a3_addr = 32'h1004; a3_rd = 1'b1;
        wait_resp(3, c1);
        @(posedge clk); #1;
        a3_addr = 32'h1010;
        wait_resp(3, c2);
        chk("b2b_total_cycles", 32'(c1 + c2), 32'd8);
        @(posedge clk); #1;
        a3_rd = 1'b0;

        // N=3: write in the last WAIT cycle is seen by the read
        do_write(3, 32'h100C, 32'h01020304, 4'hF, 1'b0);
        push_exp(3, 32'h5A5A5A5A, 1'b0);
        a3_addr = 32'h100C; a3_rd = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a3_wdata = 32'h5A5A5A5A; a3_be = 4'hF; a3_wr = 1'b1;
        @(posedge clk); #1;
        a3_wr = 1'b0;
        wait_resp(3, c1);
        @(posedge clk); #1;
        a3_rd = 1'b0;

        // N=3: out-of-window read abandoned during WAIT still completes
        a3_addr = 32'h0FFC; a3_rd = 1'b1;
        @(posedge clk); #1;
        a3_rd = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_wait_err", {31'b0, d3_err}, 32'h0);
        chk("abort_wait_wr", {31'b0, d3_wait}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_resp_err", {31'b0, d3_err}, 32'h1);
        chk("abort_resp_wait", {31'b0, d3_wait}, 32'h0);
        chk("abort_resp_rdata", d3_rdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_after_err", {31'b0, d3_err}, 32'h0);

        // N=3: reset in the 2nd WAIT cycle, read held through reset restarts
        do_read(3, 32'h1004, 32'h600DF00D, 1'b0);
        a3_addr = 32'h1004; a3_rd = 1'b1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdata", d3_rdata, 32'h0);
        chk("midrst_err", {31'b0, d3_err}, 32'h0);
        chk("midrst_wait", {31'b0, d3_wait}, 32'h1);
        chk("midrst_d1_rdata", d1_rdata, 32'h0);
        push_exp(3, 32'h600DF00D, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_resp(3, c1);
        chk("restart_cycles", 32'(c1), 32'd4);
        @(posedge clk); #1;
        a3_rd = 1'b0;
        @(posedge clk); #1;

        chk("q1_drained", 32'(q1.size()), 32'h0);
        chk("q3_drained", 32'(q3.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
